// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: op encodings (also used by decode), FSM states
// and small helpers for access size and alignment.
// Optional feature macro: LSU_ALIGN_CHECK_EN (adds the FAULT state).
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LBU = 3'd1,
        LSU_LH  = 3'd2,
        LSU_LHU = 3'd3,
        LSU_LW  = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
`ifdef LSU_ALIGN_CHECK_EN
        ,
        StFault = 2'd3
`endif
    } lsu_state_t;

    localparam logic [3:0] LSU_BE_ALL = 4'b1111;

    function automatic logic lsu_is_store(lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    // Low address bits that are illegal for the access size.
    function automatic logic lsu_misaligned(lsu_op_t op, logic [1:0] a);
        unique case (op)
            LSU_LH, LSU_LHU, LSU_SH: return a[0];
            LSU_LW, LSU_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    // Clear the low bits the access size does not allow (align down).
    function automatic logic [1:0] lsu_align(lsu_op_t op, logic [1:0] a);
        unique case (op)
            LSU_LH, LSU_LHU, LSU_SH: return {a[1], 1'b0};
            LSU_LW, LSU_SW:          return 2'b00;
            default:                 return a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic for the load/store unit.
// Ports: op_i/a_i (op and byte offset), wdata_i (store data), rdata_i (memory read data),
//        be_o (byte enables), wdata_o (lane-replicated store data), ld_data_o (extended load).
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{a_i, 3'b000} +: 8];
    assign half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o      = LSU_BE_ALL;
        wdata_o   = wdata_i;
        ld_data_o = rdata_i;
        unique case (op_i)
            LSU_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: ld_data_o = {24'd0, byte_sel};
            LSU_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: ld_data_o = {16'd0, half_sel};
            LSU_LW:  ld_data_o = rdata_i;
            LSU_SB: begin
                be_o    = 4'b0001 << a_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_SH: begin
                be_o    = a_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            LSU_SW:  ;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one byte/half/word access per transaction over a
// req/ready handshake, stalling execute via ex_ready while busy.
// Ports: clk/reset (sync active-high); ex_* op from execute; mem_* memory handshake;
//        done/wb_we/wb_rd/wb_data toward writeback; fault misalignment pulse.
// Optional feature macro: LSU_ALIGN_CHECK_EN -- misaligned accesses fault instead of
// being aligned down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [2:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              fault
);

    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       wb_data_q;

    lsu_op_t     ex_op_t;
    logic        busy;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;

    assign ex_op_t = lsu_op_t'(ex_op);
    assign busy    = (state_q == StBusy);

    lsu_lane_mux u_lane_mux (
        .op_i      (op_q),
        .a_i       (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= LSU_LB;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && ex_valid) begin
                op_q    <= ex_op_t;
                // Aligning down is harmless when the check is on: misaligned ops fault.
                addr_q  <= {ex_addr[ADDR_W-1:2], lsu_align(ex_op_t, ex_addr[1:0])};
                wdata_q <= ex_wdata;
                rd_q    <= ex_rd;
            end
            if (busy && mem_ready && !lsu_is_store(op_q)) begin
                wb_data_q <= ld_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ex_ready = 1'b0;
        mem_req  = 1'b0;
        done     = 1'b0;
        wb_we    = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ex_ready = 1'b1;
                if (ex_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
                    state_d = lsu_misaligned(ex_op_t, ex_addr[1:0]) ? StFault : StBusy;
`else
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                wb_we   = !lsu_is_store(op_q) && (rd_q != 5'd0);
                state_d = StIdle;
            end
`ifdef LSU_ALIGN_CHECK_EN
            StFault: begin
                fault   = 1'b1;
                state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Memory-side outputs are driven only while a request is outstanding.
    assign mem_we    = busy && lsu_is_store(op_q);
    assign mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = busy ? lane_be : 4'b0000;
    assign mem_wdata = busy ? lane_wdata : 32'd0;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against a
// size/offset arithmetic reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_wb = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_rd     (ex_rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .done      (done),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; memory answers after 'waits' stall cycles with 'rdata'.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] rdata, input int waits);
        int          size;
        int          off;
        bit          store;
        bit          sgn;
        bit          mis;
        logic [31:0] val;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;

        store = (op >= 3'd5);
        sgn   = (op == LSU_LB) || (op == LSU_LH);
        if (op == LSU_LB || op == LSU_LBU || op == LSU_SB) size = 1;
        else if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) size = 2;
        else size = 4;
        off = int'(addr[1:0]);
        mis = (off % size) != 0;
        if (!Chk) off = off - (off % size);

        exp_be = store ? 4'(((1 << size) - 1) << off) : 4'hf;
        if (size == 1) exp_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
        else if (size == 2) exp_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
        else exp_wd = wd;

        check("ready_before_accept", ex_ready, 1'b1);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wd;
        ex_rd    = rd;
        mem_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        ex_addr  = $urandom;
        ex_wdata = $urandom;
        ex_rd    = 5'($urandom);

        if (Chk && mis) begin
            check("fault_pulse", fault, 1'b1);
            check("fault_no_req", mem_req, 1'b0);
            check("fault_no_done", done, 1'b0);
            tick();
            check("fault_clears", fault, 1'b0);
            check("fault_ready_after", ex_ready, 1'b1);
            check("fault_no_req_after", mem_req, 1'b0);
            check("fault_wb_hold", wb_data, last_wb);
            return;
        end

        check("req_high", mem_req, 1'b1);
        check("ready_low_busy", ex_ready, 1'b0);
        check("mem_we", mem_we, store);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_be", mem_be, exp_be);
        if (store) check("mem_wdata", mem_wdata, exp_wd);
        for (int i = 0; i < waits; i++) begin
            mem_rdata = $urandom;
            tick();
            check("req_held", mem_req, 1'b1);
            check("no_done_wait", done, 1'b0);
            check("addr_held", mem_addr, {addr[31:2], 2'b00});
            check("be_held", mem_be, exp_be);
        end

        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = $urandom;

        if (!store) begin
            val = rdata >> (8 * off);
            if (size == 1) begin
                val = val & 32'hff;
                if (sgn && val[7]) val = val | 32'hffff_ff00;
            end else if (size == 2) begin
                val = val & 32'hffff;
                if (sgn && val[15]) val = val | 32'hffff_0000;
            end
            last_wb = val;
        end
        check("done_pulse", done, 1'b1);
        check("wb_we", wb_we, !store && rd != 5'd0);
        check("wb_rd", wb_rd, rd);
        check("wb_data", wb_data, last_wb);
        check("req_drop", mem_req, 1'b0);
        check("no_fault", fault, 1'b0);
        tick();
        check("done_clears", done, 1'b0);
        check("ready_after", ex_ready, 1'b1);
        check("wb_hold", wb_data, last_wb);
    endtask

    initial begin
        reset     = 1'b1;
        ex_valid  = 1'b0;
        ex_op     = 3'd0;
        ex_addr   = 32'd0;
        ex_wdata  = 32'd0;
        ex_rd     = 5'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", ex_ready, 1'b1);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", mem_be, 4'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", done, 1'b0);
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_fault", fault, 1'b0);

        // Stray mem_ready while idle must be ignored.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("idle_ready_ignored_done", done, 1'b0);
        check("idle_ready_ignored_req", mem_req, 1'b0);

        run_op(LSU_SW,  32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 32'h1234_5678, 2);
        run_op(LSU_SB,  32'h0000_0103, 32'h0000_00A5, 5'd0, 32'h0, 0);
        run_op(LSU_LB,  32'h0000_0102, 32'h0, 5'd5, 32'h0080_0000, 1);
        check("lb_directed", wb_data, 32'hFFFF_FF80);
        run_op(LSU_LBU, 32'h0000_0102, 32'h0, 5'd5, 32'h0080_0000, 0);
        check("lbu_directed", wb_data, 32'h0000_0080);
        run_op(LSU_LH,  32'h0000_0102, 32'h0, 5'd0, 32'h8001_1234, 0);
        check("lh_directed", wb_data, 32'hFFFF_8001);
        run_op(LSU_LW,  32'h0000_0101, 32'h0, 5'd7, 32'hCAFE_F00D, 1);
        run_op(LSU_SH,  32'h0000_0206, 32'h0000_BEEF, 5'd1, 32'h0, 3);

        // Reset while a request is outstanding.
        ex_valid = 1'b1;
        ex_op    = LSU_SW;
        ex_addr  = 32'h0000_0200;
        ex_wdata = 32'h1111_2222;
        ex_rd    = 5'd9;
        tick();
        ex_valid = 1'b0;
        check("rstbusy_req_before", mem_req, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_wb = 32'd0;
        check("rstbusy_req", mem_req, 1'b0);
        check("rstbusy_ready", ex_ready, 1'b1);
        check("rstbusy_wb_data", wb_data, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rstbusy_late_ready_done", done, 1'b0);
        check("rstbusy_late_ready_req", mem_req, 1'b0);
        tick();
        check("rstbusy_no_done", done, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, r, $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
